// File: rtl/read_and_d_fetcher.sv
// Sweeps a contiguous ROM address range and streams {addr, base, D} tuples through a small output FIFO.
// Optional FETCH_STALL_CNT_EN adds a saturating stall_cnt output counting backpressured cycles.
module read_and_d_fetcher #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_ce,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_read_i,
  input  logic [7:0]        mem_d_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [1:0]        out_base,
  output logic [7:0]        out_d
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = ADDR_W + 10;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] next_addr;
  logic [LEN_W-1:0]  remaining;
  logic [TW-1:0]     fifo_mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic              accept, issue, push, pop;

  assign accept    = (state == IDLE) && start;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A ROM read completes in the cycle mem_ce is high, so at most one fetch is ever in flight.
  assign push      = mem_ce;
  assign occupancy = {1'b0, count} + (CW+1)'(mem_ce) - (CW+1)'(pop);
  assign issue     = (state == RUN) && (remaining != '0) && (occupancy < (CW+1)'(DEPTH));

  assign {out_addr, out_base, out_d} = fifo_mem[rd_ptr];

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (len == '0) ? DONE : RUN;
      RUN:   if (remaining == '0) state_nx = DRAIN;
      DRAIN: if ((count == '0) && !mem_ce) state_nx = DONE;
      DONE:  state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_ce    <= 1'b0;
      mem_addr  <= '0;
      next_addr <= '0;
      remaining <= '0;
    end else begin
      state  <= state_nx;
      done   <= (state == DONE);
      mem_ce <= issue;
      if (accept) begin
        busy      <= 1'b1;
        next_addr <= start_addr;
        remaining <= len;
      end else if (state == DONE) begin
        busy <= 1'b0;
      end
      if (issue) begin
        mem_addr  <= next_addr;
        next_addr <= next_addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  // NOTE: the FIFO storage is reset because the head tuple is visible on the outputs and must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {mem_addr, mem_read_i, mem_d_i};
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if (busy && out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_read_and_d_fetcher.sv
// Scoreboard bench for read_and_d_fetcher: stimulus pushes expected tuples, a negedge monitor pops and compares.
module tb_read_and_d_fetcher;

  localparam int ADDR_W = 8;
  localparam int LEN_W  = 9;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [7:0] addr;
    logic [1:0] base;
    logic [7:0] d;
  } tuple_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  len;
  logic              busy, done, mem_ce;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_read_i;
  logic [7:0]        mem_d_i;
  logic              out_valid, out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [1:0]        out_base;
  logic [7:0]        out_d;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int occ = 0;
  int pops = 0;
  int done_cnt = 0;
  int first_valid_cyc = -1;
  int start_cyc = 0;
  int done_cyc = 0;
  int seen [256];
  bit rand_ready = 1'b0;
  bit hold_pending = 1'b0;
  tuple_t hold_t;
  tuple_t exp_q [$];
  logic [7:0] ce_log [$];
  int ce_cyc [$];
  logic [7:0] out_log [$];

  read_and_d_fetcher #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .mem_ce(mem_ce), .mem_addr(mem_addr),
    .mem_read_i(mem_read_i), .mem_d_i(mem_d_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_base(out_base), .out_d(out_d)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [1:0] rom_base(input logic [7:0] a);
    return a[1:0] ^ a[5:4];
  endfunction

  function automatic logic [7:0] rom_d(input logic [7:0] a);
    return (a ^ 8'h5A) + {a[3:0], a[7:4]};
  endfunction

  assign mem_read_i = mem_ce ? rom_base(mem_addr) : 2'b00;
  assign mem_d_i    = mem_ce ? rom_d(mem_addr)    : 8'h00;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) if (rand_ready) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: scoreboard pops, hold rule, occupancy bound and done/busy relation.
  always @(negedge clk) begin
    tuple_t act, t;
    if (rst) begin
      occ = 0;
      hold_pending = 1'b0;
    end else begin
      act = '{addr: out_addr, base: out_base, d: out_d};
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (hold_pending && out_valid) check(act == hold_t, "hold_stable", 32'(act), 32'(hold_t));
      hold_pending = out_valid && !out_ready;
      hold_t = act;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_tuple", 32'(act), 0);
        end else begin
          t = exp_q.pop_front();
          check(act == t, "tuple", 32'(act), 32'(t));
        end
        seen[out_addr]++;
        out_log.push_back(out_addr);
        pops++;
      end
      if (mem_ce) begin
        ce_log.push_back(mem_addr);
        ce_cyc.push_back(cyc);
      end
      occ = occ + int'(mem_ce) - int'(out_valid && out_ready);
      if (mem_ce) check(occ <= DEPTH, "fifo_overflow", occ, DEPTH);
      if (done) begin
        done_cnt++;
        check(!busy, "busy_at_done", busy, 0);
      end
    end
  end

  task automatic clear_logs();
    ce_log.delete();
    ce_cyc.delete();
    out_log.delete();
    pops = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
    foreach (seen[i]) seen[i] = 0;
  endtask

  task automatic push_expected(input logic [7:0] a0, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = a0 + 8'(i);
      exp_q.push_back('{addr: a, base: rom_base(a), d: rom_d(a)});
    end
  endtask

  task automatic do_start(input logic [7:0] a, input logic [8:0] l);
    @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = a;
    len = l;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    check(busy, "busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(done, name, done, 1);
    done_cyc = cyc;
    @(negedge clk);
    check(!done, "done_one_cycle", done, 0);
    check(done_cnt == 1, "done_count", done_cnt, 1);
    check(!busy, "busy_after_done", busy, 0);
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] wrap_exp [4];
    int n, bad;
    rst = 1'b1;
    start = 1'b0;
    start_addr = '0;
    len = '0;
    out_ready = 1'b1;
    #1;
    check({busy, done, mem_ce, mem_addr, out_valid, out_addr, out_base, out_d} == '0, "reset_state",
          {busy, done, mem_ce, mem_addr, out_valid, out_addr, out_base, out_d}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic fetch: ROM contents for addresses 0..3 computed by hand.
    clear_logs();
    exp_q.push_back('{addr: 8'h00, base: 2'd0, d: 8'h5A});
    exp_q.push_back('{addr: 8'h01, base: 2'd1, d: 8'h6B});
    exp_q.push_back('{addr: 8'h02, base: 2'd2, d: 8'h78});
    exp_q.push_back('{addr: 8'h03, base: 2'd3, d: 8'h89});
    do_start(8'h00, 9'd4);
    wait_done(50, "basic_done");
    check(ce_log.size() == 4, "basic_ce_count", ce_log.size(), 4);
    if (ce_log.size() == 4) begin
      check(ce_cyc[3] - ce_cyc[0] == 3, "basic_ce_consecutive", ce_cyc[3] - ce_cyc[0], 3);
      for (int i = 0; i < 4; i++) check(ce_log[i] == 8'(i), "basic_ce_addr", ce_log[i], i);
    end
    check(first_valid_cyc == start_cyc + 3, "basic_latency", first_valid_cyc, start_cyc + 3);

    // Zero length: straight to DONE, no ROM access, no output.
    clear_logs();
    do_start(8'h10, 9'd0);
    wait_done(10, "zero_done");
    check(done_cyc == start_cyc + 2, "zero_done_cycle", done_cyc, start_cyc + 2);
    check(ce_log.size() == 0, "zero_no_ce", ce_log.size(), 0);
    check(first_valid_cyc < 0, "zero_no_valid", first_valid_cyc, 32'hFFFFFFFF);

    // Backpressure: ten stalled cycles with a full FIFO.
    clear_logs();
    out_ready = 1'b0;
    push_expected(8'h40, 8);
    do_start(8'h40, 9'd8);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(out_valid, "bp_first_valid", out_valid, 1);
    repeat (10) @(posedge clk);
    check(ce_log.size() == DEPTH, "bp_issues_before_stall", ce_log.size(), DEPTH);
    #1 out_ready = 1'b1;
    wait_done(100, "bp_done");
    check(pops == 8, "bp_pops", pops, 8);
`ifdef FETCH_STALL_CNT_EN
    check(stall_cnt == 16'd10, "bp_stall_cnt", stall_cnt, 10);
`endif

    // Wrap-around past 8'hFF.
    clear_logs();
    wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    push_expected(8'hFE, 4);
    do_start(8'hFE, 9'd4);
    wait_done(50, "wrap_done");
    check(out_log.size() == 4, "wrap_count", out_log.size(), 4);
    if (out_log.size() == 4)
      for (int i = 0; i < 4; i++) check(out_log[i] == wrap_exp[i], "wrap_addr", out_log[i], wrap_exp[i]);

    // Full sweep with random backpressure.
    clear_logs();
    push_expected(8'h00, 256);
    rand_ready = 1'b1;
    do_start(8'h00, 9'd256);
    wait_done(4000, "sweep_done");
    rand_ready = 1'b0;
    #2 out_ready = 1'b1;
    check(pops == 256, "sweep_pops", pops, 256);
    bad = 0;
    foreach (seen[i]) if (seen[i] != 1) bad++;
    check(bad == 0, "sweep_coverage", bad, 0);

    // Reset mid-run after three tuples, then a fresh request.
    clear_logs();
    push_expected(8'h20, 10);
    do_start(8'h20, 9'd10);
    n = 0;
    while (pops < 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check(pops >= 3, "midrst_three_tuples", pops, 3);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check({busy, done, mem_ce, mem_addr, out_valid, out_addr, out_base, out_d} == '0, "midrst_outputs_zero",
          {busy, done, mem_ce, mem_addr, out_valid, out_addr, out_base, out_d}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    repeat (20) @(posedge clk);
    #1;
    check(done_cnt == 0, "midrst_no_done", done_cnt, 0);
    check(ce_log.size() == 0, "midrst_no_ce", ce_log.size(), 0);
    push_expected(8'h80, 3);
    do_start(8'h80, 9'd3);
    wait_done(50, "midrst_restart_done");
    check(pops == 3, "midrst_restart_pops", pops, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
